serial_word_reducer: RTL and testbench
======================================

Name: serial_word_reducer

Overview:
- Parametrised successor to the single-channel serial-in / 32-bit-result project block.
- Deserialises a bit stream MSB-first into WIDTH-bit words and reduces N_WORDS words into one result (modular sum or XOR), selected by MODE.
- Uses the same ready/done handshake style, adds a start request and an in_valid qualifier, and sits between the serial front end and the result consumer.

Parameters:
- WIDTH, 32: word and result width in bits; must be at least 2.
- N_WORDS, 4: words reduced per operation; must be at least 1.
- MODE, 0: reduction operator; 0 = sum modulo 2^WIDTH, 1 = bitwise XOR.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin an operation; honoured only in IDLE or DONE.
- in_valid  in  1  the serial bit on `in` is valid this cycle.
- in  in  1  serial data bit, MSB of each word first.
- ready  out  1  block accepts a bit this cycle.
- result  out  WIDTH  reduction result; held stable until the next accepted start.
- done  out  1  one-cycle pulse when result is updated.
- word_cnt  out  clog2(N_WORDS+1)  words reduced so far in the current operation.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state goes to IDLE.
  - ready=0, done=0, result=0, word_cnt=0.
  - Shift register, bit counter and accumulator are cleared.
  - Reset wins over every other input, including mid-operation; the partial word and accumulator are discarded.
- States: IDLE, SHIFT, ACCUM, DONE.
- IDLE:
  - ready=0.
  - start=1 → SHIFT; accumulator=0, bit counter=0, word_cnt=0.
- SHIFT:
  - ready=1.
  - A bit is accepted only when in_valid && ready: shreg <= {shreg[WIDTH-2:0], in}, bit counter increments.
  - in_valid=0 stalls with no state change; gaps of any length are legal.
  - On acceptance of bit WIDTH-1 → ACCUM on the same edge.
  - start is ignored in SHIFT.
- ACCUM (exactly one cycle):
  - ready=0; in is ignored even if in_valid=1.
  - Accumulator <= acc op shreg, where op is + truncated to WIDTH (carry discarded) or ^.
  - word_cnt increments and bit counter clears.
  - If word_cnt reaches N_WORDS → DONE, with result <= new accumulator and done=1 for that one cycle. Otherwise → SHIFT.
- DONE:
  - ready=0; done is high only in the first cycle after entry.
  - result and word_cnt hold.
  - start=1 → SHIFT, clearing the accumulator and word_cnt; result is NOT cleared.
  - Start can be accepted in the same cycle that done is high.
- Latency: the bit-accepted edge is k. done is high in the cycle following edge k+1, i.e. 2 cycles after the last bit.
- Minimum operation length: N_WORDS*(WIDTH+1) cycles from the first ready.
- Simultaneous start and in_valid in IDLE/DONE: the bit is not accepted, because ready=0 in those states.
- All outputs are registered.

Decomposition:
- Shared package holds:
  - the state enum typedef (IDLE, SHIFT, ACCUM, DONE);
  - MODE constants MODE_SUM=0 and MODE_XOR=1;
  - a counter-width function built on clog2.
- One natural sub-module, serial_shifter: a WIDTH-bit shift register plus bit counter.
  - Inputs: shift_en and clear.
  - Outputs: word and word_full (pulse on the last bit).
- The FSM and accumulator stay in the top module.

Test Plan:
- Reset/idle: assert rst for 2 cycles, then hold idle for 10 cycles → ready=0, done=0, result=0, word_cnt=0 throughout.
- Sum with wrap: MODE=0, WIDTH=32, N_WORDS=4. Words 0x00000001, 0xFFFFFFFF, 0x00000002, 0x00000003 with continuous in_valid → result=0x00000005, exactly one done pulse, done 2 cycles after the last bit, word_cnt=4.
- XOR mode: MODE=1. Words 0xA5A5A5A5, 0x5A5A5A5A, 0x00000000, 0xFFFFFFFF → result=0x00000000.
- XOR mode: MODE=1. Words 0x12345678, 0, 0, 0 → result=0x12345678.
- Stalls and ignored inputs:
  - Random in_valid gaps (30% duty) with the sum vectors → same result 0x00000005.
  - Bits presented during ACCUM are not consumed.
  - start pulsed in SHIFT has no effect.
- Reset mid-operation:
  - Assert rst after 2.5 words → IDLE with all outputs zero.
  - Then start a fresh op with words 1,1,1,1 → result=0x00000004.
- Back-to-back operations: start asserted in the done cycle, second op words 7,7,7,7 → the first result is held until the second done, then result=0x0000001C.

Source files
------------

// File: rtl/serial_word_reducer_pkg.sv
// Shared types and helpers for the serial word reducer.
// Holds the FSM encoding, reduction mode codes and counter sizing.
package serial_word_reducer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        ACCUM,
        DONE
    } state_t;

    localparam int MODE_SUM = 0;
    localparam int MODE_XOR = 1;

    // Bits needed to count from 0 up to and including n.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/serial_word_reducer_shifter.sv
// MSB-first shift register with a bit counter.
// word_full marks the cycle in which the last bit of a word is taken.
module serial_shifter
    import serial_word_reducer_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             shift_en,
    input  logic             in,
    output logic [WIDTH-1:0] word,
    output logic             word_full
);

    localparam int CW = cnt_width(WIDTH);

    logic [CW-1:0] bit_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            word    <= '0;
            bit_cnt <= '0;
        end else if (clear) begin
            bit_cnt <= '0;
        end else if (shift_en) begin
            word    <= {word[WIDTH-2:0], in};
            bit_cnt <= bit_cnt + 1'b1;
        end
    end

    assign word_full = shift_en && (bit_cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/serial_word_reducer.sv
// Deserialises MSB-first words and folds N_WORDS of them into one result.
// MODE selects modular sum or bitwise XOR as the reduction.
module serial_word_reducer
    import serial_word_reducer_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int N_WORDS = 4,
    parameter int MODE    = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           in_valid,
    input  logic                           in,
    output logic                           ready,
    output logic [WIDTH-1:0]               result,
    output logic                           done,
    output logic [cnt_width(N_WORDS)-1:0]  word_cnt
);

    localparam int WCW = cnt_width(N_WORDS);

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_n;
    logic [WIDTH-1:0] result_n;
    logic [WCW-1:0]   word_cnt_n;
    logic             done_n;
    logic             ready_n;
    logic             sh_clear;
    logic             shift_en;
    logic [WIDTH-1:0] word;
    logic             word_full;

    assign shift_en = in_valid && ready;

    serial_shifter #(
        .WIDTH(WIDTH)
    ) u_shifter (
        .clk      (clk),
        .rst      (rst),
        .clear    (sh_clear),
        .shift_en (shift_en),
        .in       (in),
        .word     (word),
        .word_full(word_full)
    );

    always_comb begin
        state_n    = state;
        acc_n      = acc;
        result_n   = result;
        word_cnt_n = word_cnt;
        done_n     = 1'b0;
        sh_clear   = 1'b0;
        unique case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_n    = SHIFT;
                    acc_n      = '0;
                    word_cnt_n = '0;
                    sh_clear   = 1'b1;
                end
            end
            SHIFT: begin
                if (word_full) begin
                    state_n = ACCUM;
                end
            end
            ACCUM: begin
                acc_n      = (MODE == MODE_XOR) ? (acc ^ word) : (acc + word);
                word_cnt_n = word_cnt + 1'b1;
                sh_clear   = 1'b1;
                if (word_cnt_n == WCW'(N_WORDS)) begin
                    state_n  = DONE;
                    result_n = acc_n;
                    done_n   = 1'b1;
                end else begin
                    state_n = SHIFT;
                end
            end
            default: state_n = IDLE;
        endcase
        ready_n = (state_n == SHIFT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            acc      <= '0;
            result   <= '0;
            word_cnt <= '0;
            done     <= 1'b0;
            ready    <= 1'b0;
        end else begin
            state    <= state_n;
            acc      <= acc_n;
            result   <= result_n;
            word_cnt <= word_cnt_n;
            done     <= done_n;
            ready    <= ready_n;
        end
    end

endmodule

// File: tb/tb_serial_word_reducer.sv
// Scoreboard bench for serial_word_reducer: a sum-mode and an XOR-mode
// instance share one stimulus stream; a monitor checks each done pulse.
module tb_serial_word_reducer;

    typedef logic [31:0] vec_t [4];

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        in_bit;

    logic        ready_s, done_s, ready_x, done_x;
    logic [31:0] result_s, result_x;
    logic [2:0]  wc_s, wc_x;

    int tests = 0;
    int fails = 0;

    logic [31:0] qs[$];
    logic [31:0] qx[$];

    always #5 clk = ~clk;

    serial_word_reducer #(.WIDTH(32), .N_WORDS(4), .MODE(0)) dut_s (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in(in_bit), .ready(ready_s), .result(result_s), .done(done_s),
        .word_cnt(wc_s)
    );

    serial_word_reducer #(.WIDTH(32), .N_WORDS(4), .MODE(1)) dut_x (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
        .in(in_bit), .ready(ready_x), .result(result_x), .done(done_x),
        .word_cnt(wc_x)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst === 1'b0 && done_s === 1'b1) begin
            if (qs.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sum_unexpected_done: got result %h", result_s);
            end else begin
                chk("sum_result", 64'(result_s), 64'(qs.pop_front()));
            end
            chk("sum_word_cnt", 64'(wc_s), 64'd4);
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b0 && done_x === 1'b1) begin
            if (qx.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL xor_unexpected_done: got result %h", result_x);
            end else begin
                chk("xor_result", 64'(result_x), 64'(qx.pop_front()));
            end
            chk("xor_word_cnt", 64'(wc_x), 64'd4);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_s"}, 64'({ready_s, done_s, wc_s, result_s}), 64'd0);
        chk({name, "_x"}, 64'({ready_x, done_x, wc_x, result_x}), 64'd0);
    endtask

    // Drives nbits bits; junk drives in_valid with noise while ready is low.
    task automatic send_bits(input vec_t w, input int nbits, input int duty,
                             input bit junk, input bit poke);
        int          idx   = 0;
        int          guard = 0;
        bit          v;
        bit          acc;
        logic [31:0] cur;
        while (idx < nbits && guard < 3000) begin
            cur = w[idx / 32];
            if (ready_s) begin
                v      = (duty >= 100) || (int'($urandom_range(99)) < duty);
                in_bit = cur[31 - (idx % 32)];
            end else begin
                v      = junk;
                in_bit = 1'($urandom_range(1));
            end
            in_valid = v;
            start    = poke && (idx == 40);
            acc      = v && ready_s;
            tick();
            if (acc) idx++;
            guard++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        in_bit   = 1'b0;
        if (idx < nbits) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: got %0d bits expected %0d", idx, nbits);
        end
    endtask

    task automatic run_op(input vec_t w, input logic [31:0] es,
                          input logic [31:0] ex, input int duty,
                          input bit junk, input bit poke);
        qs.push_back(es);
        qx.push_back(ex);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ready_after_start", 64'(ready_s), 64'd1);
        send_bits(w, 128, duty, junk, poke);
        chk("accum_ready_low", 64'(ready_s), 64'd0);
        tick();
        chk("done_latency", 64'({done_s, done_x}), 64'b11);
        tick();
        chk("done_one_pulse", 64'({done_s, done_x}), 64'b00);
        chk("result_hold", 64'({result_s, result_x}), {es, ex});
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_bit   = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            chk_zero("idle_zero");
            tick();
        end

        // Sum with carry wrap; XOR of same words is 0xFFFFFFFF.
        run_op('{32'h00000001, 32'hFFFFFFFF, 32'h00000002, 32'h00000003},
               32'h00000005, 32'hFFFFFFFF, 100, 1'b1, 1'b0);

        run_op('{32'hA5A5A5A5, 32'h5A5A5A5A, 32'h00000000, 32'hFFFFFFFF},
               32'hFFFFFFFE, 32'h00000000, 100, 1'b1, 1'b0);

        run_op('{32'h12345678, 32'h0, 32'h0, 32'h0},
               32'h12345678, 32'h12345678, 100, 1'b0, 1'b0);

        // Gaps, noise during ACCUM and a start pulse inside SHIFT.
        run_op('{32'h00000001, 32'hFFFFFFFF, 32'h00000002, 32'h00000003},
               32'h00000005, 32'hFFFFFFFF, 30, 1'b1, 1'b1);

        // Abort after 2.5 words.
        start = 1'b1;
        tick();
        start = 1'b0;
        send_bits('{32'h00000001, 32'hFFFFFFFF, 32'h00000002, 32'h00000003},
                  80, 100, 1'b0, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_zero("midop_reset");
        tick();
        chk_zero("post_reset_idle");

        run_op('{32'h1, 32'h1, 32'h1, 32'h1},
               32'h00000004, 32'h00000000, 100, 1'b0, 1'b0);

        // Back-to-back: restart in the done cycle.
        qs.push_back(32'h00000005);
        qx.push_back(32'hFFFFFFFF);
        start = 1'b1;
        tick();
        start = 1'b0;
        send_bits('{32'h00000001, 32'hFFFFFFFF, 32'h00000002, 32'h00000003},
                  128, 100, 1'b1, 1'b0);
        tick();
        chk("b2b_first_done", 64'(done_s), 64'd1);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("b2b_restart_ready", 64'(ready_s), 64'd1);
        chk("b2b_hold_early", 64'({result_s, result_x}),
            {32'h00000005, 32'hFFFFFFFF});
        qs.push_back(32'h0000001C);
        qx.push_back(32'h00000000);
        send_bits('{32'h7, 32'h7, 32'h7, 32'h7}, 128, 100, 1'b1, 1'b0);
        chk("b2b_hold_late", 64'({result_s, result_x}),
            {32'h00000005, 32'hFFFFFFFF});
        tick();
        chk("b2b_second_done", 64'({done_s, done_x}), 64'b11);
        tick();
        chk("b2b_result", 64'({result_s, result_x}),
            {32'h0000001C, 32'h00000000});

        repeat (3) tick();
        chk("sum_queue_empty", 64'(qs.size()), 64'd0);
        chk("xor_queue_empty", 64'(qx.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
